ccff_chain_loader: RTL and testbench
====================================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 32, sets the number of configuration flops in the downstream ccff chain; legal range is 1 to 65535.
REQ-002 Parameter WORD_W, default 8, sets the width of a host configuration word; legal range is 1 to 32.
REQ-003 prog_clk  in  1  The single clock; all state changes on its rising edge.
REQ-004 prog_reset  in  1  Asynchronous, active-high reset.
REQ-005 start  in  1  Single-cycle request to begin a pass; sampled only in IDLE.
REQ-006 verify  in  1  Pass mode, sampled together with start: 0 selects LOAD, 1 selects VERIFY.
REQ-007 cfg_data  in  WORD_W  Host configuration word; MSB is shifted first.
REQ-008 cfg_valid  in  1  cfg_data is valid.
REQ-009 cfg_ready  out  1  The loader accepts the word this cycle.
REQ-010 ccff_head  out  1  Serial bit driven to the chain head.
REQ-011 ccff_clk_en  out  1  Chain shift enable for the external clock gate; the chain shifts on exactly those prog_clk edges where this is 1.
REQ-012 ccff_tail  in  1  Serial bit returned from the chain tail.
REQ-013 busy  out  1  High in LOAD or VERIFY.
REQ-014 done  out  1  One-cycle pulse when a pass ends.
REQ-015 error  out  1  Sticky verify-mismatch flag.
REQ-016 mismatch_cnt  out  16  Count of mismatched bits, saturating at 16'hFFFF.

Function
REQ-017 The FSM states SHALL be IDLE, LOAD, VERIFY and DONE.
REQ-018 IDLE SHALL move to LOAD on start with verify=0, and to VERIFY on start with verify=1; start SHALL be ignored in every other state.
REQ-019 Entering LOAD or VERIFY SHALL clear bit_cnt to 0; entering VERIFY SHALL also clear error and mismatch_cnt.
REQ-020 Words SHALL transfer on cfg_valid && cfg_ready.
REQ-021 cfg_ready SHALL be high only in LOAD or VERIFY, only while the one-word hold buffer is empty, and only while fewer than CHAIN_LEN bits are fetched or in flight.
REQ-022 The hold buffer SHALL feed a WORD_W shift register, so a continuous cfg_valid stream produces one shifted bit per cycle with no bubble.
REQ-023 ccff_clk_en SHALL be 1 exactly in cycles where the shift register holds a valid bit and bit_cnt < CHAIN_LEN; ccff_head SHALL then equal the shift-register MSB.
REQ-024 When ccff_clk_en is 0, ccff_head SHALL be 0.
REQ-025 Each cycle with ccff_clk_en=1 SHALL increment bit_cnt by 1.
REQ-026 When CHAIN_LEN is not a multiple of WORD_W, the unused low bits of the last word SHALL be discarded and no further word SHALL be requested.
REQ-027 In VERIFY, on every cycle with ccff_clk_en=1, ccff_tail SHALL be compared with ccff_head. This works because the host re-sends the stream from the prior LOAD, and bit k leaving the tail equals bit k previously loaded.
REQ-028 On each VERIFY mismatch, the loader SHALL set error and increment mismatch_cnt, saturating.
REQ-029 When bit_cnt reaches CHAIN_LEN, the FSM SHALL go to DONE; DONE SHALL assert done for one cycle and then return to IDLE.
REQ-030 error and mismatch_cnt SHALL hold their values through IDLE until the next VERIFY start or reset.
REQ-031 When cfg_valid is low, the loader SHALL stall with ccff_clk_en=0 and the chain contents unchanged.

Reset
REQ-032 prog_reset SHALL asynchronously force: state IDLE; cfg_ready, ccff_head, ccff_clk_en, busy, done and error all 0; mismatch_cnt 0; buffers and bit_cnt cleared.
REQ-033 A reset asserted mid-pass SHALL abort the pass with no done pulse, leaving the chain partially loaded; the host SHALL restart with a full LOAD.

Structure
REQ-034 A shared package ccff_loader_pkg SHALL hold the FSM state enum and the mismatch_cnt width constant (16).
REQ-035 The bit_cnt width SHALL be derived from CHAIN_LEN as ceil(log2(CHAIN_LEN+1)).
REQ-036 One sub-module, ccff_word_serializer, SHALL own the hold buffer, the shift register and the bit-valid tracking; the FSM, counting and compare logic SHALL sit in the top.

Verification
REQ-037 Scenario 1: CHAIN_LEN=32, WORD_W=8; LOAD with words 0xA5,0x3C,0xFF,0x01 sent back-to-back -> ccff_clk_en high for exactly 32 consecutive cycles; head sequence 10100101 00111100 11111111 00000001; one done pulse; a behavioral 32-flop chain model holds the stream.
REQ-038 Scenario 2: LOAD as in scenario 1, then VERIFY with the same words -> error=0 and mismatch_cnt=0 at done.
REQ-039 Scenario 3: VERIFY with the second word changed to 0x3D -> error=1 and mismatch_cnt=1.
REQ-040 Scenario 4: CHAIN_LEN=10, WORD_W=8 -> exactly 2 words accepted, 10 shifts, and the low 6 bits of word 2 never driven.
REQ-041 Scenario 5: cfg_valid dropped for 5 cycles mid-word -> ccff_clk_en=0 for those cycles, chain model unchanged, and the final contents match scenario 1.
REQ-042 Scenario 6: prog_reset asserted at bit 17 -> all outputs 0 immediately, no done pulse; start asserted while busy is ignored.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// ----------------------------------------------------------------------------
// ccff_loader_pkg
// Shared types and constants for the ccff chain loader.
//   state_t        : loader FSM states (IDLE, LOAD, VERIFY, DONE)
//   MISMATCH_CNT_W : width of the verify mismatch counter
//   sat_inc()      : saturating increment for the mismatch counter
// ----------------------------------------------------------------------------
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int MISMATCH_CNT_W = 16;

    // Counts up but sticks at all-ones so a long bad verify never wraps to a
    // small, misleading value.
    function automatic logic [MISMATCH_CNT_W-1:0] sat_inc(
        input logic [MISMATCH_CNT_W-1:0] value
    );
        return (&value) ? value : value + MISMATCH_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// ----------------------------------------------------------------------------
// ccff_chain_loader_if
// Host configuration-word handshake.
//   cfg_data  : configuration word, MSB shifted into the chain first
//   cfg_valid : cfg_data is valid
//   cfg_ready : loader accepts the word this cycle
// Modports: master = host side, slave = loader side.
// ----------------------------------------------------------------------------
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// ----------------------------------------------------------------------------
// ccff_word_serializer
// One-word hold buffer feeding a WORD_W shift register. The shift register is
// reloaded from the hold buffer in the same cycle its last bit leaves, so a
// continuous word stream yields one bit per cycle with no bubble.
//   prog_clk, prog_reset : clock, asynchronous active-high reset
//   clear                : synchronous flush of both buffers (between passes)
//   load_word, word_in   : write a word into the (empty) hold buffer
//   shift_en             : consume the current MSB this cycle
//   hold_full            : hold buffer occupied
//   bit_valid            : shift register holds at least one unsent bit
//   msb                  : current shift-register MSB
// ----------------------------------------------------------------------------
module ccff_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              clear,
    input  logic              load_word,
    input  logic [WORD_W-1:0] word_in,
    input  logic              shift_en,
    output logic              hold_full,
    output logic              bit_valid,
    output logic              msb
);

    localparam int SR_CNT_W = $clog2(WORD_W + 1);
    localparam logic [SR_CNT_W-1:0] SR_FULL = SR_CNT_W'(WORD_W);
    localparam logic [SR_CNT_W-1:0] SR_ONE  = SR_CNT_W'(1);

    logic [WORD_W-1:0]   hold_data;
    logic [WORD_W-1:0]   shift_reg;
    logic [SR_CNT_W-1:0] sr_cnt;
    logic                reload;

    // Reload when the shift register is empty now or empties this cycle.
    always_comb begin
        // NOTE: default first so every path assigns reload and no latch is inferred.
        reload = 1'b0;
        if (hold_full && (sr_cnt == '0 || (sr_cnt == SR_ONE && shift_en))) begin
            reload = 1'b1;
        end
    end

    // load_word only arrives while the hold buffer is empty and reload only
    // fires while it is full, so the two never collide.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (prog_reset) begin
            // NOTE: data buffers are reset too, so a stale word can never leak into a new pass.
            hold_data <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            sr_cnt    <= '0;
        end else if (clear) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            sr_cnt    <= '0;
        end else begin
            if (load_word) begin
                hold_data <= word_in;
                hold_full <= 1'b1;
            end else if (reload) begin
                hold_full <= 1'b0;
            end

            if (reload) begin
                shift_reg <= hold_data;
                sr_cnt    <= SR_FULL;
            end else if (shift_en) begin
                shift_reg <= shift_reg << 1;
                sr_cnt    <= sr_cnt - SR_ONE;
            end
        end
    end

    assign bit_valid = (sr_cnt != '0);
    assign msb       = shift_reg[WORD_W-1];

endmodule

// File: rtl/ccff_chain_loader.sv
// ----------------------------------------------------------------------------
// ccff_chain_loader
// Streams host configuration words MSB-first into a CHAIN_LEN-flop ccff chain
// (LOAD), or re-streams them while comparing the bits leaving the chain tail
// against the bits being shifted in (VERIFY).
//   prog_clk, prog_reset : clock, asynchronous active-high reset
//   start, verify        : begin a pass from IDLE; verify selects VERIFY mode
//   cfg_bus (slave)      : cfg_data / cfg_valid / cfg_ready word handshake
//   ccff_head            : serial bit into the chain (0 when not shifting)
//   ccff_clk_en          : chain shifts on every edge where this is 1
//   ccff_tail            : serial bit returned from the chain tail
//   busy                 : high in LOAD or VERIFY
//   done                 : one-cycle pulse when a pass completes
//   error, mismatch_cnt  : sticky verify mismatch flag and saturating count
// ----------------------------------------------------------------------------
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8
) (
    input  logic                      prog_clk,
    input  logic                      prog_reset,
    input  logic                      start,
    input  logic                      verify,
    ccff_chain_loader_if.slave        cfg_bus,
    output logic                      ccff_head,
    output logic                      ccff_clk_en,
    input  logic                      ccff_tail,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [MISMATCH_CNT_W-1:0] mismatch_cnt
);

    localparam int BIT_CNT_W  = $clog2(CHAIN_LEN + 1);
    // Words needed to cover the chain; the last one may be partially used.
    localparam int NUM_WORDS  = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int WORD_CNT_W = $clog2(NUM_WORDS + 1);

    localparam logic [BIT_CNT_W-1:0]  CHAIN_LEN_C = BIT_CNT_W'(CHAIN_LEN);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT_C  = BIT_CNT_W'(CHAIN_LEN - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE     = BIT_CNT_W'(1);
    localparam logic [WORD_CNT_W-1:0] NUM_WORDS_C = WORD_CNT_W'(NUM_WORDS);
    localparam logic [WORD_CNT_W-1:0] WORD_ONE    = WORD_CNT_W'(1);

    state_t                state;
    state_t                state_next;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [WORD_CNT_W-1:0] word_cnt;

    logic in_pass;
    logic pass_start;
    logic cfg_ready;
    logic accept;
    logic shift;
    logic last_shift;
    logic hold_full;
    logic bit_valid;
    logic sr_msb;

    assign in_pass    = (state == LOAD) || (state == VERIFY);
    assign pass_start = (state == IDLE) && start;

    // Stop requesting once every word the chain needs has been fetched; the
    // low bits of a partial last word are flushed when the pass ends.
    assign cfg_ready         = in_pass && !hold_full && (word_cnt < NUM_WORDS_C);
    assign cfg_bus.cfg_ready = cfg_ready;
    assign accept            = cfg_bus.cfg_valid && cfg_ready;

    assign shift       = in_pass && bit_valid && (bit_cnt < CHAIN_LEN_C);
    assign last_shift  = shift && (bit_cnt == LAST_BIT_C);
    assign ccff_clk_en = shift;
    assign ccff_head   = shift & sr_msb;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .clear      (!in_pass),
        .load_word  (accept),
        .word_in    (cfg_bus.cfg_data),
        .shift_en   (shift),
        .hold_full  (hold_full),
        .bit_valid  (bit_valid),
        .msb        (sr_msb)
    );

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = verify ? VERIFY : LOAD;
                end
            end
            LOAD, VERIFY: begin
                busy = 1'b1;
                if (last_shift) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else if (pass_start) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (shift) begin
                bit_cnt <= bit_cnt + BIT_ONE;
            end
            if (accept) begin
                word_cnt <= word_cnt + WORD_ONE;
            end
        end
    end

    // The host re-sends the previously loaded stream, so bit k leaving the
    // tail must equal bit k entering the head.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            error        <= 1'b0;
            mismatch_cnt <= '0;
        end else if (pass_start && verify) begin
            error        <= 1'b0;
            mismatch_cnt <= '0;
        end else if ((state == VERIFY) && shift && (ccff_tail != sr_msb)) begin
            error        <= 1'b1;
            mismatch_cnt <= sat_inc(mismatch_cnt);
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ----------------------------------------------------------------------------
// tb_ccff_chain_loader
// Directed bench for two loader instances (32-bit and 10-bit chains, 8-bit
// words), each driving a behavioral flop-chain model. Host signals are shared;
// sel routes start to one instance at a time, the idle one never accepts.
// ----------------------------------------------------------------------------
module tb_ccff_chain_loader;
    import ccff_loader_pkg::*;

    logic prog_clk = 1'b0;
    logic prog_reset;
    always #5 prog_clk = ~prog_clk;

    logic       host_start, host_verify, host_valid, sel, abort;
    logic [7:0] host_data;
    logic       host_ready;
    int         checks = 0;
    int         errors = 0;

    ccff_chain_loader_if #(.WORD_W(8)) bus32 ();
    ccff_chain_loader_if #(.WORD_W(8)) bus10 ();

    assign bus32.cfg_data  = host_data;
    assign bus32.cfg_valid = host_valid;
    assign bus10.cfg_data  = host_data;
    assign bus10.cfg_valid = host_valid;
    assign host_ready      = sel ? bus10.cfg_ready : bus32.cfg_ready;

    logic start32, start10;
    assign start32 = host_start && !sel;
    assign start10 = host_start && sel;

    logic                      head32, en32, busy32, done32, err32;
    logic [MISMATCH_CNT_W-1:0] mcnt32;
    logic [31:0]               chain32 = '0;
    logic                      head10, en10, busy10, done10, err10;
    logic [MISMATCH_CNT_W-1:0] mcnt10;
    logic [9:0]                chain10 = '0;

    ccff_chain_loader #(.CHAIN_LEN(32), .WORD_W(8)) dut32 (
        .prog_clk     (prog_clk),
        .prog_reset   (prog_reset),
        .start        (start32),
        .verify       (host_verify),
        .cfg_bus      (bus32),
        .ccff_head    (head32),
        .ccff_clk_en  (en32),
        .ccff_tail    (chain32[31]),
        .busy         (busy32),
        .done         (done32),
        .error        (err32),
        .mismatch_cnt (mcnt32)
    );

    ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(8)) dut10 (
        .prog_clk     (prog_clk),
        .prog_reset   (prog_reset),
        .start        (start10),
        .verify       (host_verify),
        .cfg_bus      (bus10),
        .ccff_head    (head10),
        .ccff_clk_en  (en10),
        .ccff_tail    (chain10[9]),
        .busy         (busy10),
        .done         (done10),
        .error        (err10),
        .mismatch_cnt (mcnt10)
    );

    // Behavioral chains: flop 0 at the head, tail is the top bit. Not reset.
    always @(posedge prog_clk) if (en32 === 1'b1) chain32 <= {chain32[30:0], head32};
    always @(posedge prog_clk) if (en10 === 1'b1) chain10 <= {chain10[8:0], head10};

    // Monitors, sampled mid-cycle.
    int          en_cnt32 = 0, done_cnt32 = 0, acc_cnt32 = 0, run32 = 0, last_run32 = 0, idle_bad32 = 0;
    logic [31:0] seq32 = '0;
    int          en_cnt10 = 0, done_cnt10 = 0, acc_cnt10 = 0, idle_bad10 = 0;
    logic [9:0]  seq10 = '0;

    always @(negedge prog_clk) begin
        if (en32 === 1'b1) begin
            en_cnt32 <= en_cnt32 + 1;
            run32    <= run32 + 1;
            seq32    <= {seq32[30:0], head32};
        end else begin
            if (run32 != 0) last_run32 <= run32;
            run32 <= 0;
            if (head32 !== 1'b0) idle_bad32 <= idle_bad32 + 1;
        end
        if (done32 === 1'b1) done_cnt32 <= done_cnt32 + 1;
        if (bus32.cfg_valid === 1'b1 && bus32.cfg_ready === 1'b1) acc_cnt32 <= acc_cnt32 + 1;
    end

    always @(negedge prog_clk) begin
        if (en10 === 1'b1) begin
            en_cnt10 <= en_cnt10 + 1;
            seq10    <= {seq10[8:0], head10};
        end else if (head10 !== 1'b0) begin
            idle_bad10 <= idle_bad10 + 1;
        end
        if (done10 === 1'b1) done_cnt10 <= done_cnt10 + 1;
        if (bus10.cfg_valid === 1'b1 && bus10.cfg_ready === 1'b1) acc_cnt10 <= acc_cnt10 + 1;
    end

    int b_en, b_done, b_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic mark(input logic which);
        b_en   = which ? en_cnt10   : en_cnt32;
        b_done = which ? done_cnt10 : done_cnt32;
        b_acc  = which ? acc_cnt10  : acc_cnt32;
    endtask

    task automatic pulse_start(input logic mode);
        host_verify = mode;
        host_start  = 1'b1;
        tick();
        host_start  = 1'b0;
        host_verify = 1'b0;
    endtask

    // Sends words first..first+n-1 of a 4-word stream (word 0 = stream[31:24]).
    task automatic send_words(input logic [31:0] stream, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            logic got;
            got        = 1'b0;
            host_data  = stream[31-8*i -: 8];
            host_valid = 1'b1;
            for (int c = 0; c < 100 && !got && !abort; c++) begin
                @(negedge prog_clk);
                got = host_ready;
                tick();
            end
            if (!abort) check($sformatf("accept_word%0d", i), 32'(got), 32'd1);
        end
        host_valid = 1'b0;
    endtask

    task automatic wait_done(input logic which, output logic seen);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge prog_clk);
            seen = which ? done10 : done32;
            tick();
        end
    endtask

    initial begin
        logic        seen;
        logic [31:0] snap;
        logic [31:0] s6;

        host_start = 1'b0; host_verify = 1'b0; host_valid = 1'b0; host_data = '0;
        sel = 1'b0; abort = 1'b0; prog_reset = 1'b1;
        repeat (2) tick();

        // Reset state
        check("rst_ready32", 32'(bus32.cfg_ready), 32'd0);
        check("rst_outs32", {26'd0, head32, en32, busy32, done32, err32, 1'b0}, 32'd0);
        check("rst_mcnt32", 32'(mcnt32), 32'd0);
        check("rst_outs10", {26'd0, bus10.cfg_ready, head10, en10, busy10, done10, err10}, 32'd0);
        prog_reset = 1'b0;
        tick();

        // Scenario 1: back-to-back LOAD
        mark(1'b0);
        pulse_start(1'b0);
        check("s1_busy", 32'(busy32), 32'd1);
        send_words(32'hA53CFF01, 0, 4);
        wait_done(1'b0, seen);
        check("s1_done_seen", 32'(seen), 32'd1);
        tick();
        check("s1_shifts", en_cnt32 - b_en, 32'd32);
        check("s1_consecutive", last_run32, 32'd32);
        check("s1_head_seq", seq32, 32'hA53CFF01);
        check("s1_chain", chain32, 32'hA53CFF01);
        check("s1_done_pulses", done_cnt32 - b_done, 32'd1);
        check("s1_accepted", acc_cnt32 - b_acc, 32'd4);
        check("s1_idle_busy", 32'(busy32), 32'd0);

        // Scenario 2: VERIFY with identical stream
        mark(1'b0);
        pulse_start(1'b1);
        send_words(32'hA53CFF01, 0, 4);
        wait_done(1'b0, seen);
        check("s2_done_seen", 32'(seen), 32'd1);
        check("s2_error", 32'(err32), 32'd0);
        check("s2_mcnt", 32'(mcnt32), 32'd0);
        check("s2_shifts", en_cnt32 - b_en, 32'd32);

        // Scenario 3: VERIFY with word 1 = 0x3D (one bit differs)
        mark(1'b0);
        pulse_start(1'b1);
        send_words(32'hA53DFF01, 0, 4);
        wait_done(1'b0, seen);
        check("s3_done_seen", 32'(seen), 32'd1);
        check("s3_error", 32'(err32), 32'd1);
        check("s3_mcnt", 32'(mcnt32), 32'd1);
        check("s3_chain", chain32, 32'hA53DFF01);
        repeat (4) tick();
        check("s3_error_held", 32'(err32), 32'd1);
        check("s3_mcnt_held", 32'(mcnt32), 32'd1);

        // Scenario 4: 10-flop chain, partial last word
        sel = 1'b1;
        mark(1'b1);
        pulse_start(1'b0);
        send_words(32'hA53CFF01, 0, 2);
        host_data  = 8'hFF;
        host_valid = 1'b1;
        wait_done(1'b1, seen);
        host_valid = 1'b0;
        check("s4_done_seen", 32'(seen), 32'd1);
        check("s4_accepted", acc_cnt10 - b_acc, 32'd2);
        check("s4_shifts", en_cnt10 - b_en, 32'd10);
        check("s4_head_seq", 32'(seq10), 32'h294);
        check("s4_chain", 32'(chain10), 32'h294);
        check("s4_done_pulses", done_cnt10 - b_done, 32'd1);
        check("s4_head_idle", idle_bad10, 32'd0);
        check("s4_dut32_idle_acc", acc_cnt32, 32'd12);
        sel = 1'b0;

        // Scenario 5: stream stalls after word 0 drains
        mark(1'b0);
        pulse_start(1'b0);
        send_words(32'hA53CFF01, 0, 1);
        repeat (9) tick();
        check("s5_pre_gap_shifts", en_cnt32 - b_en, 32'd8);
        check("s5_pre_gap_chain", chain32, 32'h3DFF01A5);
        snap = chain32;
        for (int i = 0; i < 5; i++) begin
            @(negedge prog_clk);
            check($sformatf("s5_gap_en%0d", i), {30'd0, en32, head32}, 32'd0);
            tick();
        end
        check("s5_gap_chain", chain32, snap);
        send_words(32'hA53CFF01, 1, 3);
        wait_done(1'b0, seen);
        check("s5_done_seen", 32'(seen), 32'd1);
        check("s5_shifts", en_cnt32 - b_en, 32'd32);
        check("s5_chain", chain32, 32'hA53CFF01);
        check("s5_error_kept", 32'(err32), 32'd1);

        // Scenario 6a: start (verify=1) while busy is ignored
        mark(1'b0);
        pulse_start(1'b0);
        fork
            send_words(32'hA53CFF01, 0, 4);
            begin
                repeat (12) tick();
                pulse_start(1'b1);
            end
        join
        wait_done(1'b0, seen);
        check("s6_busy_start_done", 32'(seen), 32'd1);
        check("s6_busy_start_shifts", en_cnt32 - b_en, 32'd32);
        check("s6_busy_start_err", 32'(err32), 32'd1);
        check("s6_busy_start_mcnt", 32'(mcnt32), 32'd1);

        // Scenario 6b: reset at bit 17
        s6 = 32'hA53CFF01;
        mark(1'b0);
        pulse_start(1'b0);
        fork
            send_words(s6, 0, 4);
            begin
                for (int c = 0; c < 200 && (en_cnt32 - b_en) < 17; c++) tick();
                check("s6_reach17", en_cnt32 - b_en, 32'd17);
                #1;
                prog_reset = 1'b1;
                abort      = 1'b1;
                #1;
                check("s6_rst_outs", {26'd0, bus32.cfg_ready, head32, en32, busy32, done32, err32}, 32'd0);
                check("s6_rst_mcnt", 32'(mcnt32), 32'd0);
            end
        join
        repeat (3) tick();
        check("s6_no_done", done_cnt32 - b_done, 32'd0);
        check("s6_partial_chain", 32'(chain32[16:0]), 32'(s6[31:15]));
        check("s6_head_idle", idle_bad32, 32'd0);
        prog_reset = 1'b0;
        abort      = 1'b0;
        tick();

        // Host restarts with a full LOAD
        mark(1'b0);
        pulse_start(1'b0);
        send_words(s6, 0, 4);
        wait_done(1'b0, seen);
        check("s6_reload_done", 32'(seen), 32'd1);
        check("s6_reload_chain", chain32, 32'hA53CFF01);
        check("s6_reload_shifts", en_cnt32 - b_en, 32'd32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
